// File: rtl/fsk_receiver.sv
// FSK link receiver: tone demodulator, start-bit framer and 12-bit deserializer,
// plus a free-running bit-rate divider. Optional majority filter: FSK_RX_FILTER_EN.
module fsk_receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 12,
  parameter int MARK_HALF    = 2,
  parameter int SPACE_HALF   = 4,
  parameter int THRESH       = 3
) (
  input  logic                 sysclk,
  input  logic                 rst,
  input  logic                 signal_mod,
  output logic                 bit_clk,
  output logic                 signal_out,
  output logic [DATA_BITS-1:0] RX_Data,
  output logic                 RX_Status
);

  localparam int HALF    = CLKS_PER_BIT / 2;
  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int IDX_W   = $clog2(DATA_BITS);
  localparam int RUN_MAX = 2 * SPACE_HALF + 1;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  // a mark half-period must always decode as 1, whatever THRESH is set to
  localparam int THR     = (THRESH < MARK_HALF) ? MARK_HALF : THRESH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] NEXT  = 2'd3;

  logic [CNT_W-1:0] div_cnt;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst)                                      div_cnt <= '0;
    else if (div_cnt == CNT_W'(CLKS_PER_BIT - 1)) div_cnt <= '0;
    else                                          div_cnt <= div_cnt + 1'b1;
  end

  assign bit_clk = (div_cnt >= CNT_W'(HALF));

  logic             sync1, sync2, sync_d;
  logic [RUN_W-1:0] run;
  logic             dec;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      sync_d <= 1'b1;
      run    <= '0;
      dec    <= 1'b1;
    end else begin
      sync1  <= signal_mod;
      sync2  <= sync1;
      sync_d <= sync2;
      if (sync2 != sync_d) begin
        dec <= (run <= RUN_W'(THR));
        run <= RUN_W'(1);
      end else if (run != RUN_W'(RUN_MAX)) begin
        run <= run + 1'b1;
      end else begin
        dec <= 1'b1;  // carrier lost: line reads idle
      end
    end
  end

`ifdef FSK_RX_FILTER_EN
  logic [1:0] hist;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) hist <= 2'b11;
    else     hist <= {hist[0], dec};
  end

  assign signal_out = (dec & hist[0]) | (dec & hist[1]) | (hist[0] & hist[1]);
`else
  assign signal_out = dec;
`endif

  logic                 so_d;
  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-2:0] shreg;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      so_d      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      RX_Data   <= '0;
      RX_Status <= 1'b0;
    end else begin
      so_d      <= signal_out;
      RX_Status <= 1'b0;
      case (state)
        IDLE: begin
          // the fall is seen one cycle after it happened, so the count starts at 1
          if (so_d && !signal_out) begin
            state <= START;
            cnt   <= CNT_W'(1);
          end
        end
        START: begin
          if (cnt == CNT_W'(HALF - 1)) begin
            cnt <= '0;
            idx <= '0;
            state <= signal_out ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            shreg <= {shreg[DATA_BITS-3:0], signal_out};
            if (idx == IDX_W'(DATA_BITS - 1)) begin
              RX_Data   <= {shreg, signal_out};
              RX_Status <= 1'b1;
              state     <= NEXT;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        NEXT: begin
          // sampling one slot after the last data bit lands on a contiguous start bit's center
          if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt <= '0;
            idx <= '0;
            state <= signal_out ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_receiver.sv
// Self-checking bench for fsk_receiver: phase-continuous FSK carrier generator,
// passive output monitor and a frame-level expected-word model.
module tb_fsk_receiver;
  localparam int CPB = 16;
  localparam int DB  = 12;

  logic          sysclk = 1'b0;
  logic          rst = 1'b1;
  logic          signal_mod = 1'b1;
  logic          bit_clk, signal_out, RX_Status;
  logic [DB-1:0] RX_Data;

  fsk_receiver #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .MARK_HALF(2), .SPACE_HALF(4), .THRESH(3)
  ) dut (
    .sysclk(sysclk), .rst(rst), .signal_mod(signal_mod), .bit_clk(bit_clk),
    .signal_out(signal_out), .RX_Data(RX_Data), .RX_Status(RX_Status)
  );

  always #5 sysclk = ~sysclk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int            st_cyc[$];
  logic [DB-1:0] st_dat[$];
  int            fall_cyc[$];
  logic          so_prev = 1'b1;

  always @(negedge sysclk) begin
    if (RX_Status === 1'b1) begin
      st_cyc.push_back(cyc);
      st_dat.push_back(RX_Data);
    end
    if (so_prev === 1'b1 && signal_out === 1'b0) fall_cyc.push_back(cyc);
    so_prev = signal_out;
  end

  logic          sig = 1'b1;
  int            hc = 0;
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] last_word = '0;

  task automatic tone(input logic b, input int n);
    repeat (n) begin
      @(posedge sysclk); #2;
      hc++;
      if (hc >= (b ? 2 : 4)) begin
        sig = ~sig;
        hc  = 0;
      end
      signal_mod = sig;
    end
  endtask

  task automatic send_word(input logic [DB-1:0] w);
    tone(1'b0, CPB);
    for (int i = DB - 1; i >= 0; i--) tone(w[i], CPB);
    exp_q.push_back(w);
    last_word = w;
  endtask

  task automatic clear_q();
    st_cyc.delete(); st_dat.delete(); fall_cyc.delete(); exp_q.delete();
  endtask

  task automatic check_words(input string name);
    n_cmp++;
    if (st_dat.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL %s count: got %0d frames want %0d", name, st_dat.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (st_dat[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL %s word%0d: got %h want %h", name, i, st_dat[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic exp_bc;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    n_cmp += 4;
    if (bit_clk !== 1'b0)    begin n_bad++; $display("FAIL reset bit_clk: got %b want 0", bit_clk); end
    if (signal_out !== 1'b1) begin n_bad++; $display("FAIL reset signal_out: got %b want 1", signal_out); end
    if (RX_Data !== '0)      begin n_bad++; $display("FAIL reset RX_Data: got %h want 000", RX_Data); end
    if (RX_Status !== 1'b0)  begin n_bad++; $display("FAIL reset RX_Status: got %b want 0", RX_Status); end
    @(posedge sysclk); #2; rst = 1'b0;
    for (int j = 0; j < 48; j++) begin
      @(negedge sysclk);
      exp_bc = ((j % CPB) >= CPB / 2);
      n_cmp++;
      if (bit_clk !== exp_bc) begin
        n_bad++;
        $display("FAIL bit_clk j=%0d: got %b want %b", j, bit_clk, exp_bc);
      end
    end
    tone(1'b1, 60);
  endtask

  task automatic test_single_frame();
    clear_q();
    send_word(12'hAAA);
    tone(1'b1, 40);
    check_words("single");
    if (st_cyc.size() > 0 && fall_cyc.size() > 0) begin
      n_cmp++;
      if (st_cyc[0] - fall_cyc[0] !== 200) begin
        n_bad++;
        $display("FAIL single latency: got %0d want 200", st_cyc[0] - fall_cyc[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    send_word(12'hAAA);
    send_word(12'hF0C);
    send_word(12'hC3C);
    tone(1'b1, 40);
    check_words("b2b");
    if (st_cyc.size() == 3 && fall_cyc.size() > 0) begin
      n_cmp += 3;
      if (st_cyc[0] - fall_cyc[0] !== 200) begin
        n_bad++; $display("FAIL b2b latency: got %0d want 200", st_cyc[0] - fall_cyc[0]);
      end
      if (st_cyc[1] - st_cyc[0] !== 208) begin
        n_bad++; $display("FAIL b2b spacing1: got %0d want 208", st_cyc[1] - st_cyc[0]);
      end
      if (st_cyc[2] - st_cyc[1] !== 208) begin
        n_bad++; $display("FAIL b2b spacing2: got %0d want 208", st_cyc[2] - st_cyc[1]);
      end
    end
    tone(1'b1, 100);
    n_cmp++;
    if (RX_Data !== 12'hC3C) begin n_bad++; $display("FAIL b2b hold: got %h want c3c", RX_Data); end
  endtask

  task automatic test_random();
    clear_q();
    for (int f = 0; f < 6; f++) begin
      send_word(DB'($urandom));
      if ($urandom_range(0, 1) == 1) tone(1'b1, $urandom_range(24, 60));
    end
    tone(1'b1, 40);
    check_words("random");
  endtask

  task automatic test_demod();
    int first0;
    logic back1;
    tone(1'b1, 64);
    n_cmp++;
    if (signal_out !== 1'b1) begin n_bad++; $display("FAIL demod mark: got %b want 1", signal_out); end
    first0 = -1;
    back1  = 1'b0;
    for (int k = 0; k < 64; k++) begin
      tone(1'b0, 1);
      @(negedge sysclk);
      if (signal_out === 1'b0 && first0 < 0) first0 = k;
      else if (first0 >= 0 && signal_out !== 1'b0) back1 = 1'b1;
    end
    n_cmp += 2;
    if (first0 < 0 || first0 > 7) begin
      n_bad++; $display("FAIL demod space latency: got %0d want 0..7", first0);
    end
    if (back1) begin n_bad++; $display("FAIL demod space steady: got 1 want 0"); end
    tone(1'b1, 64);
    n_cmp++;
    if (signal_out !== 1'b1) begin n_bad++; $display("FAIL demod remark: got %b want 1", signal_out); end
    tone(1'b1, 260);
    last_word = RX_Data;
  endtask

  task automatic test_glitch();
    logic dipped;
    logic [DB-1:0] w;
    clear_q();
    dipped = 1'b0;
    for (int k = 0; k < 34; k++) begin
      tone(k < 4 ? 1'b0 : 1'b1, 1);
      @(negedge sysclk);
      if (signal_out === 1'b0) dipped = 1'b1;
    end
    tone(1'b1, 250);
    n_cmp += 3;
    if (!dipped) begin n_bad++; $display("FAIL glitch dip: got no dip want dip"); end
    if (st_cyc.size() !== 0) begin
      n_bad++; $display("FAIL glitch strobe: got %0d pulses want 0", st_cyc.size());
    end
    if (RX_Data !== last_word) begin
      n_bad++; $display("FAIL glitch hold: got %h want %h", RX_Data, last_word);
    end
    w = DB'($urandom);
    send_word(w);
    tone(1'b1, 40);
    check_words("after_glitch");
  endtask

  task automatic test_carrier_loss();
    int bad_samples;
    clear_q();
    bad_samples = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge sysclk); #2;
      @(negedge sysclk);
      if (signal_out !== 1'b1) bad_samples++;
    end
    hc = 0;
    tone(1'b1, 250);
    n_cmp += 2;
    if (bad_samples !== 0) begin
      n_bad++; $display("FAIL loss idle: got %0d low samples want 0", bad_samples);
    end
    if (st_cyc.size() !== 0) begin
      n_bad++; $display("FAIL loss strobe: got %0d pulses want 0", st_cyc.size());
    end
  endtask

  task automatic test_midframe_reset();
    logic [DB-1:0] w;
    clear_q();
    w = 12'h0A5;
    tone(1'b0, CPB);
    for (int i = DB - 1; i >= DB - 6; i--) tone(w[i], CPB);
    @(posedge sysclk); #2; rst = 1'b1;
    #1;
    n_cmp += 4;
    if (bit_clk !== 1'b0)    begin n_bad++; $display("FAIL mid rst bit_clk: got %b want 0", bit_clk); end
    if (signal_out !== 1'b1) begin n_bad++; $display("FAIL mid rst signal_out: got %b want 1", signal_out); end
    if (RX_Data !== '0)      begin n_bad++; $display("FAIL mid rst RX_Data: got %h want 000", RX_Data); end
    if (RX_Status !== 1'b0)  begin n_bad++; $display("FAIL mid rst RX_Status: got %b want 0", RX_Status); end
    tone(1'b1, 3);
    rst = 1'b0;
    tone(1'b1, 300);
    n_cmp++;
    if (st_cyc.size() !== 0) begin
      n_bad++; $display("FAIL mid rst strobe: got %0d pulses want 0", st_cyc.size());
    end
    send_word(DB'($urandom));
    tone(1'b1, 40);
    check_words("after_reset");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_random();
    test_demod();
    test_glitch();
    test_carrier_loss();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
